// File: rtl/intf_array_reader_pkg.sv
// Shared types and constants for intf_array_reader.
//   state_t    : scanner FSM encoding
//   SCAN_CNT_W : width of the completed-pass counter
//   evt_width  : packed {idx, level} event width for a given array size
package intf_array_reader_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam int SCAN_CNT_W = 8;

    function automatic int evt_width(input int n_intf);
        return $clog2(n_intf) + 1;
    endfunction

endpackage

// File: rtl/intf_array_reader_if.sv
// foo_intf: one single-bit field `a` per array element.
//   master : drives a (the writer side)
//   slave  : reads a (intf_array_reader side)
interface foo_intf;
    logic a;

    modport master (output a);
    modport slave  (input  a);
endinterface

// File: rtl/intf_evt_fifo.sv
// Synchronous event FIFO with a registered head.
//   clk, rst            : clock, synchronous active-high reset
//   push, push_data     : write request; dropped when full unless a pop
//                         happens on the same edge
//   pop                 : read request; ignored when empty
//   pop_data            : registered head entry, all-zero when empty
//   full, empty         : registered occupancy flags
module intf_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_inc;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic [WIDTH-1:0] head_nxt;
    logic             do_pop;
    logic             do_push;

    // Pop is resolved first, so a full FIFO can still take a push on the
    // same edge that frees a slot.
    assign do_pop     = pop && !empty;
    assign do_push    = push && (!full || do_pop);
    assign rd_ptr_inc = rd_ptr + AW'(1);

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + ONE_CNT;
        end else if (do_pop && !do_push) begin
            count_nxt = count - ONE_CNT;
        end
    end

    // Head is kept in a register so the consumer sees flopped data; it
    // follows whichever entry will sit at rd_ptr after this edge.
    always_comb begin
        head_nxt = pop_data;
        if (count_nxt == '0) begin
            head_nxt = '0;
        end else if (empty || (do_pop && count == ONE_CNT)) begin
            head_nxt = push_data;
        end else if (do_pop) begin
            head_nxt = mem[rd_ptr_inc];
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            pop_data <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            count    <= count_nxt;
            pop_data <= head_nxt;
            full     <= (count_nxt == FULL_CNT);
            empty    <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/intf_array_reader.sv
// Round-robin poller over an array of foo_intf. Each SCAN cycle samples one
// element's `a`; a level change versus the last accepted level is queued as
// an {idx, level} event on a valid/ready stream.
//   clk, rst      : clock, synchronous active-high reset
//   foos[]        : interface array, only .a is read
//   enable        : scan enable
//   evt_valid/evt_ready/evt_idx/evt_level : event stream (registered head)
//   overflow      : sticky, an event was dropped on a full queue
//   scan_count    : completed passes over the array, wraps
//
// state | meaning
// IDLE  | not sampling; ptr and prev[] hold
// SCAN  | sample foos[ptr].a every edge, advance ptr
module intf_array_reader
    import intf_array_reader_pkg::*;
#(
    parameter  int N_INTF     = 2,
    parameter  int FIFO_DEPTH = 4,
    localparam int IDX_W      = $clog2(N_INTF)
) (
    input  logic                  clk,
    input  logic                  rst,
    foo_intf.slave                foos [N_INTF-1:0],
    input  logic                  enable,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [IDX_W-1:0]      evt_idx,
    output logic                  evt_level,
    output logic                  overflow,
    output logic [SCAN_CNT_W-1:0] scan_count
);
    localparam int EVT_W = evt_width(N_INTF);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INTF - 1);

    logic [N_INTF-1:0] cur;
    logic [N_INTF-1:0] prev;
    logic [IDX_W-1:0]  ptr;
    state_t            state;
    state_t            state_nxt;
    logic              scanning;
    logic              change;
    logic              pop;
    logic              push;
    logic              accept;
    logic              fifo_full;
    logic              fifo_empty;
    logic [EVT_W-1:0]  push_data;
    logic [EVT_W-1:0]  head_data;

    // Elements are only ever addressed with constant indices; the variable
    // selection happens on the flattened vector.
    for (genvar gi = 0; gi < N_INTF; gi++) begin : g_flat
        assign cur[gi] = foos[gi].a;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable)  state_nxt = SCAN;
            SCAN:    if (!enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        scanning = 1'b0;
        case (state)
            SCAN:    scanning = 1'b1;
            default: scanning = 1'b0;
        endcase
    end

    assign change    = cur[ptr] != prev[ptr];
    assign pop       = evt_valid && evt_ready;
    assign push      = scanning && change;
    assign accept    = push && (!fifo_full || pop);
    assign push_data = {ptr, cur[ptr]};

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= '0;
            prev       <= '0;
            overflow   <= 1'b0;
            scan_count <= '0;
        end else if (scanning) begin
            // A dropped change leaves prev untouched so a later pass
            // re-detects it.
            if (accept) begin
                prev[ptr] <= cur[ptr];
            end else if (push) begin
                overflow <= 1'b1;
            end
            if (ptr == LAST_IDX) begin
                ptr        <= '0;
                scan_count <= scan_count + SCAN_CNT_W'(1);
            end else begin
                ptr <= ptr + IDX_W'(1);
            end
        end
    end

    intf_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign evt_valid            = !fifo_empty;
    assign {evt_idx, evt_level} = head_data;

endmodule
